// File: rtl/sel_arbiter.sv
// sel_arbiter: registered two-requester round-robin arbiter that drives the
// select line of the 2:1 source mux directly downstream.
//
// Sel only moves on the edge that leaves IDLE/GAP for a grant state, so the
// mux never switches while either grant is high. Every release passes
// through exactly one GAP cycle before the next grant.
//
// Parameters:
//   HOLD_MAX  maximum grant length in cycles before forced release (0 = none)
//   CNT_W     hold counter width, 2**CNT_W must exceed HOLD_MAX
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   ReqA     level request from source A
//   ReqB     level request from source B
//   Done     owner-finished pulse, only looked at while a grant is active
//   Sel      registered mux select (0 = A, 1 = B)
//   GntA     registered grant to A
//   GntB     registered grant to B
//   Busy     GntA | GntB
//   Timeout  one-cycle pulse in GAP after a release caused only by HOLD_MAX
module sel_arbiter #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic ReqA,
    input  logic ReqB,
    input  logic Done,
    output logic Sel,
    output logic GntA,
    output logic GntB,
    output logic Busy,
    output logic Timeout
);

    localparam int unsigned       HoldLimInt = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
    localparam logic [CNT_W-1:0]  HoldLim    = CNT_W'(HoldLimInt);
    localparam logic              TimerOn    = (HOLD_MAX != 0);

    typedef enum logic [1:0] {
        StIdle,
        StGrantA,
        StGrantB,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic               last_b_q, last_b_d;  // 1: B was served most recently
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               owner_req;
    logic               hold_hit;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_b_d  = last_b_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        owner_req = (state_q == StGrantA) ? ReqA : ReqB;
        hold_hit  = TimerOn && (cnt_q == HoldLim);

        unique case (state_q)
            StIdle, StGap: begin
                // On a tie, last_b_q picks the source that was not served last.
                if (ReqA && (!ReqB || last_b_q)) begin
                    state_d  = StGrantA;
                    sel_d    = 1'b0;
                    last_b_d = 1'b0;
                    cnt_d    = '0;
                end else if (ReqB) begin
                    state_d  = StGrantB;
                    sel_d    = 1'b1;
                    last_b_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    state_d  = StIdle;
                end
            end
            StGrantA, StGrantB: begin
                if (Done || !owner_req || hold_hit) begin
                    state_d   = StGap;
                    // Only flag the timeout when nothing else ended the grant.
                    timeout_d = hold_hit && !Done && owner_req;
                end else if (TimerOn && (cnt_q != HoldLim)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
            last_b_q  <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_b_q  <= last_b_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign GntA    = (state_q == StGrantA);
    assign GntB    = (state_q == StGrantB);
    assign Busy    = GntA | GntB;
    assign Sel     = sel_q;
    assign Timeout = timeout_q;

endmodule
